// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared state encoding and command codes for the SPI slave
package spi_slave_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_tx_shift.sv
// rtl/spi_slave_tx_shift.sv - read-byte latch and MSB-first MISO shifter
module spi_slave_tx_shift #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_miso,
   output logic             o_last
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_active;
   logic             r_miso;

   // Latch the byte and present its MSB at once; then one lower bit per cycle, 0 when done
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_sh     <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_miso   <= 1'b0;
      end else if (i_load) begin
         r_sh     <= i_data << 1;
         r_miso   <= i_data[WIDTH-1];
         r_cnt    <= CW'(WIDTH - 1);
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt == '0) begin
            r_active <= 1'b0;
            r_miso   <= 1'b0;
         end else begin
            r_miso <= r_sh[WIDTH-1];
            r_sh   <= r_sh << 1;
            r_cnt  <= r_cnt - CW'(1);
         end
      end
   end

   assign o_miso = r_miso;
   // High in the cycle the final bit is on the line; the edge that ends it completes the transmit
   assign o_last = r_active && (r_cnt == '0);

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave: command FSM, receive shifter, read handshake; SPI_SLAVE_PARITY_EN adds an odd-parity bit
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 parity_err
);
   localparam int RX_W = ADDR_SIZE + 2;
   localparam int CW   = $clog2(RX_W);

   state_t          r_state;
   state_t          w_next_state;
   logic [RX_W-1:0] r_rx_data;
   logic [CW-1:0]   r_cnt;
   logic            r_rx_valid;
   logic            r_parity_err;
   logic            r_rx_done;
   logic            r_tx_wait;
   logic            r_rd_addr_flag;

   logic w_rx_state;
   logic w_shift;
   logic w_last_bit;
   logic w_rx_complete;
   logic w_rx_ok;
   logic w_par_bad;
   logic w_par_phase;
   logic w_tx_load;
   logic w_tx_end;
   logic w_tx_last;

   assign w_rx_state = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
   assign w_shift    = w_rx_state && !SS_n && !r_rx_done && !w_par_phase;
   assign w_last_bit = w_shift && (r_cnt == '0);

`ifdef SPI_SLAVE_PARITY_EN
   logic r_par_phase;
   logic w_par_sample;
   logic w_par_good;

   // One-cycle parity slot right after the last payload bit
   always_ff @(posedge clk) begin
      if (!rst_n || SS_n || (r_state == CHK_CMD)) begin
         r_par_phase <= 1'b0;
      end else if (w_last_bit) begin
         r_par_phase <= 1'b1;
      end else if (r_par_phase) begin
         r_par_phase <= 1'b0;
      end
   end

   assign w_par_phase   = r_par_phase;
   assign w_par_sample  = r_par_phase && !SS_n;
   assign w_par_good    = ^{r_rx_data, MOSI};
   assign w_rx_complete = w_par_sample;
   assign w_rx_ok       = w_par_sample && w_par_good;
   assign w_par_bad     = w_par_sample && !w_par_good;
`else
   assign w_par_phase   = 1'b0;
   assign w_rx_complete = w_last_bit;
   assign w_rx_ok       = w_last_bit;
   assign w_par_bad     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: deselect always returns to IDLE; direction bit picks the frame type
   always_comb begin
      w_next_state = r_state;
      if (SS_n) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_next_state = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI) begin
                  w_next_state = WRITE;
               end else if (r_rd_addr_flag) begin
                  w_next_state = READ_DATA;
               end else begin
                  w_next_state = READ_ADD;
               end
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   // Receive shifter, bit counter and completion strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_cnt        <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_rx_done    <= 1'b0;
      end else begin
         r_rx_valid   <= w_rx_ok;
         r_parity_err <= w_par_bad;
         if (w_shift) begin
            r_rx_data <= {r_rx_data[RX_W-2:0], MOSI};
         end
         if (SS_n) begin
            r_cnt     <= '0;
            r_rx_done <= 1'b0;
         end else if (r_state == CHK_CMD) begin
            r_cnt     <= CW'(RX_W - 1);
            r_rx_done <= 1'b0;
         end else begin
            if (w_shift && (r_cnt != '0)) begin
               r_cnt <= r_cnt - CW'(1);
            end
            if (w_rx_complete) begin
               r_rx_done <= 1'b1;
            end
         end
      end
   end

   // Read handshake: address flag and the wait window for tx_valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx_wait      <= 1'b0;
         r_rd_addr_flag <= 1'b0;
      end else begin
         if (SS_n) begin
            r_tx_wait <= 1'b0;
         end else if (w_rx_ok && (r_state == READ_DATA)) begin
            r_tx_wait <= 1'b1;
         end else if (w_tx_load) begin
            r_tx_wait <= 1'b0;
         end
         if (w_rx_ok && (r_state == READ_ADD)) begin
            r_rd_addr_flag <= 1'b1;
         end else if (w_tx_last) begin
            r_rd_addr_flag <= 1'b0;
         end
      end
   end

   assign w_tx_load = r_tx_wait && tx_valid && !SS_n;
   assign w_tx_last = w_tx_end && !SS_n;

   spi_slave_tx_shift #(
      .WIDTH(ADDR_SIZE)
   ) u_tx_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (SS_n),
      .i_load  (w_tx_load),
      .i_data  (tx_data),
      .o_miso  (MISO),
      .o_last  (w_tx_end)
   );

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized self-checking bench for spi_slave against a frame-level model
module tb_spi_slave;
   import spi_slave_pkg::*;

   localparam int AS = 8;
   localparam int RW = AS + 2;
`ifdef SPI_SLAVE_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [RW-1:0] rx_data;
   logic          rx_valid;
   logic [AS-1:0] tx_data;
   logic          tx_valid;
   logic          parity_err;

   int n_checks = 0;
   int n_errors = 0;
   bit m_flag   = 1'b0;

   spi_slave #(.ADDR_SIZE(AS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SS_n       (SS_n),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic deselect();
      SS_n = 1'b1;
      tx_valid = 1'b0;
      tick();
      check_eq("desel_state", 32'(dut.r_state), 32'(IDLE));
      check_eq("desel_miso", 32'(MISO), 32'd0);
   endtask

   // One frame: select, direction bit, payload (+parity), optional abort at bit index abort_at
   task automatic send_frame(input bit d, input logic [RW-1:0] w, input int abort_at,
                             input bit bad_par, output bit need_tx);
      bit     q[$];
      int     nb;
      bit     ok;
      state_t exp_st;
      need_tx = 1'b0;
      for (int i = RW - 1; i >= 0; i--) q.push_back(w[i]);
      if (PB == 1) q.push_back((~(^w)) ^ bad_par);
      nb = q.size();
      exp_st = !d ? WRITE : (m_flag ? READ_DATA : READ_ADD);

      SS_n = 1'b0;
      MOSI = 1'($urandom);
      tick();
      check_eq("sel_state", 32'(dut.r_state), 32'(CHK_CMD));
      MOSI = d;
      tick();
      check_eq("dir_state", 32'(dut.r_state), 32'(exp_st));
      for (int i = 0; i < nb; i++) begin
         MOSI = q[i];
         tx_valid = 1'($urandom);
         tx_data = AS'($urandom);
         if (i == abort_at) SS_n = 1'b1;
         tick();
         if (i == abort_at) begin
            tx_valid = 1'b0;
            check_eq("abort_rxv", 32'(rx_valid), 32'd0);
            check_eq("abort_state", 32'(dut.r_state), 32'(IDLE));
            check_eq("abort_flag", 32'(dut.r_rd_addr_flag), 32'(m_flag));
            check_eq("abort_miso", 32'(MISO), 32'd0);
            return;
         end
         if (i < nb - 1) check_eq("rxv_early", 32'(rx_valid), 32'd0);
         check_eq("rx_miso", 32'(MISO), 32'd0);
      end
      tx_valid = 1'b0;
      ok = !((PB == 1) && bad_par);
      check_eq("rx_valid", 32'(rx_valid), 32'(ok));
      check_eq("rx_data", 32'(rx_data), 32'(w));
      check_eq("parity_err", 32'(parity_err), 32'(!ok));
      if (ok && d && !m_flag) m_flag = 1'b1;
      check_eq("rd_flag", 32'(dut.r_rd_addr_flag), 32'(m_flag));
      need_tx = ok && (exp_st == READ_DATA);
      for (int k = 0; k < 2; k++) begin
         MOSI = 1'($urandom);
         if (!need_tx) tx_valid = 1'($urandom);
         tick();
         check_eq("hold_rxv", 32'(rx_valid), 32'd0);
         check_eq("hold_perr", 32'(parity_err), 32'd0);
         check_eq("hold_miso", 32'(MISO), 32'd0);
         check_eq("hold_state", 32'(dut.r_state), 32'(exp_st));
         check_eq("hold_data", 32'(rx_data), 32'(w));
      end
      tx_valid = 1'b0;
   endtask

   // Read byte return: idle wait, tx_valid latch, 8 MISO bits; optional reset during bit rst_at
   task automatic do_tx(input logic [AS-1:0] data, input int wait_cycles, input int rst_at);
      tx_valid = 1'b0;
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         check_eq("txwait_miso", 32'(MISO), 32'd0);
      end
      tx_valid = 1'b1;
      tx_data = data;
      tick();
      tx_valid = 1'b0;
      tx_data = AS'($urandom);
      for (int i = 0; i < AS; i++) begin
         check_eq("miso_bit", 32'(MISO), 32'(data[AS-1-i]));
         if (i == rst_at) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            m_flag = 1'b0;
            check_eq("rst_miso", 32'(MISO), 32'd0);
            check_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
            check_eq("rst_flag", 32'(dut.r_rd_addr_flag), 32'd0);
            return;
         end
         tick();
      end
      m_flag = 1'b0;
      check_eq("tx_end_miso", 32'(MISO), 32'd0);
      check_eq("tx_end_flag", 32'(dut.r_rd_addr_flag), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit nt;
      bit d;
      logic [RW-1:0] w;
      int ab;
      bit bp;

      rst_n = 1'b0;
      SS_n = 1'b1;
      MOSI = 1'b0;
      tx_valid = 1'b0;
      tx_data = '0;
      tick();
      tick();
      check_eq("rst_rxv", 32'(rx_valid), 32'd0);
      check_eq("rst_rxd", 32'(rx_data), 32'd0);
      check_eq("rst_miso0", 32'(MISO), 32'd0);
      check_eq("rst_perr", 32'(parity_err), 32'd0);
      check_eq("rst_state0", 32'(dut.r_state), 32'(IDLE));
      check_eq("rst_flag0", 32'(dut.r_rd_addr_flag), 32'd0);
      rst_n = 1'b1;
      m_flag = 1'b0;
      tick();

      // write address 0x0A5
      send_frame(1'b0, 10'h0A5, -1, 1'b0, nt);
      deselect();

      // read address then read data returning 0x96
      send_frame(1'b1, 10'h23C, -1, 1'b0, nt);
      deselect();
      send_frame(1'b1, 10'h300, -1, 1'b0, nt);
      check_eq("need_tx", 32'(nt), 32'd1);
      if (nt) do_tx(8'h96, 2, -1);
      deselect();

      // abort after 5 bits, then a clean frame; abort on the last bit
      send_frame(1'b0, 10'h1C3, 5, 1'b0, nt);
      deselect();
      send_frame(1'b0, 10'h15A, -1, 1'b0, nt);
      deselect();
      send_frame(1'b0, 10'h0F0, RW + PB - 1, 1'b0, nt);
      deselect();

      // reset during MISO bit 3
      send_frame(1'b1, 10'h277, -1, 1'b0, nt);
      deselect();
      send_frame(1'b1, 10'h3AA, -1, 1'b0, nt);
      if (nt) do_tx(8'hC5, 1, 3);
      deselect();

`ifdef SPI_SLAVE_PARITY_EN
      send_frame(1'b0, 10'h0A5, -1, 1'b1, nt);
      deselect();
      send_frame(1'b0, 10'h0A5, -1, 1'b0, nt);
      deselect();
`endif

      for (int n = 0; n < 40; n++) begin
         d = 1'($urandom);
         w = RW'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RW + PB - 1)) : -1;
         bp = (PB == 1) && ($urandom_range(0, 2) == 0);
         send_frame(d, w, ab, bp, nt);
         if (nt) do_tx(AS'($urandom), int'($urandom_range(0, 4)), -1);
         deselect();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
